// File: rtl/demux12_stream.sv
// Registered 1-to-2 stream demultiplexer with a one-entry holding register per channel.
// It also keeps a wrapping per-channel delivery counter.
module demux12_stream #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             sel,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    chan_state_t      state0_r, state1_r;
    chan_state_t      state0_next_s, state1_next_s;
    logic [WIDTH-1:0] data0_r, data1_r;
    logic [CNT_W-1:0] cnt0_r, cnt1_r;
    logic             in_ready_s, accept_s;
    logic             load0_s, load1_s, drain0_s, drain1_s;

    // Handshake decode and per-channel next-state logic
    always_comb begin
        in_ready_s    = 1'b0;
        accept_s      = 1'b0;
        load0_s       = 1'b0;
        load1_s       = 1'b0;
        drain0_s      = 1'b0;
        drain1_s      = 1'b0;
        state0_next_s = state0_r;
        state1_next_s = state1_r;

        drain0_s = (state0_r == FULL) & out0_ready;
        drain1_s = (state1_r == FULL) & out1_ready;

        // Only the addressed channel gates acceptance, so a stalled sink never blocks the other.
        if (sel) begin
            in_ready_s = (state1_r == EMPTY) | out1_ready;
        end else begin
            in_ready_s = (state0_r == EMPTY) | out0_ready;
        end

        accept_s = in_valid & in_ready_s;
        load0_s  = accept_s & ~sel;
        load1_s  = accept_s & sel;

        case (state0_r)
            EMPTY: begin
                if (load0_s) state0_next_s = FULL;
                else         state0_next_s = EMPTY;
            end
            FULL: begin
                if (drain0_s && !load0_s) state0_next_s = EMPTY;
                else                      state0_next_s = FULL;
            end
            default: state0_next_s = EMPTY;
        endcase

        case (state1_r)
            EMPTY: begin
                if (load1_s) state1_next_s = FULL;
                else         state1_next_s = EMPTY;
            end
            FULL: begin
                if (drain1_s && !load1_s) state1_next_s = EMPTY;
                else                      state1_next_s = FULL;
            end
            default: state1_next_s = EMPTY;
        endcase
    end

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state0_r <= EMPTY;
            state1_r <= EMPTY;
        end else begin
            state0_r <= state0_next_s;
            state1_r <= state1_next_s;
        end
    end

    // Holding registers; a load overwrites the word that drains in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data0_r <= {WIDTH{1'b0}};
            data1_r <= {WIDTH{1'b0}};
        end else begin
            if (load0_s) data0_r <= in_data;
            if (load1_s) data1_r <= in_data;
        end
    end

    // Delivery counters, wrapping modulo 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_r <= {CNT_W{1'b0}};
            cnt1_r <= {CNT_W{1'b0}};
        end else begin
            if (drain0_s) cnt0_r <= cnt0_r + CNT_ONE;
            if (drain1_s) cnt1_r <= cnt1_r + CNT_ONE;
        end
    end

    assign in_ready   = in_ready_s;
    assign out0_data  = data0_r;
    assign out0_valid = (state0_r == FULL);
    assign out1_data  = data1_r;
    assign out1_valid = (state1_r == FULL);
    assign cnt0       = cnt0_r;
    assign cnt1       = cnt1_r;

endmodule
